memory_access_unit: RTL and testbench

- Memory-access pipeline stage that consumes the execute stage's outputs (address/ALU result, store data, memwrite/memaccess, load/store size) and drives them onto the data-memory bus.
- Issues data-memory requests with a valid/ready handshake and waits for a variable-latency read response.
- Formats store data and byte strobes; sign/zero-extends load data.
- Stalls the upstream pipeline while an access is in flight; presents results and control to write-back.

---
 rtl/multicore_pkg.sv | 54 +++++
 rtl/mem_align_unit.sv | 66 ++++++
 rtl/memory_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types and constants for the memory-access stage: widths, load/store
// size encodings, stage FSM states and the alignment rule.
package multicore_pkg;

  localparam int DATA_SIZE = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_AW    = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } t_ldop;

  typedef enum logic [1:0] {
    SB = 2'd0,
    SH = 2'd1,
    SW = 2'd2
  } t_sop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } t_ma_state;

  // Halfword accesses need an even address, word accesses a multiple of four;
  // byte accesses can never be misaligned.
  function automatic logic ma_misaligned(input logic       memwrite,
                                         input t_ldop      ldop,
                                         input t_sop       sop,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (memwrite) begin
      case (sop)
        SH:      mis = addr_lo[0];
        SW:      mis = |addr_lo;
        default: mis = 1'b0;
      endcase
    end else begin
      case (ldop)
        LH, LHU: mis = addr_lo[0];
        LW:      mis = |addr_lo;
        default: mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane logic for the memory stage: replicates store data across
// byte lanes with matching strobes, extracts and extends load data from the
// returned word, and flags misaligned addresses.
module mem_align_unit
  import multicore_pkg::*;
(
  input  logic [1:0]           addr_lo_i,
  input  logic                 memwrite_i,
  input  t_ldop                ldop_i,
  input  t_sop                 sop_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [DATA_SIZE-1:0] rdata_i,
  output logic [3:0]           wstrb_o,
  output logic [DATA_SIZE-1:0] wdata_o,
  output logic [DATA_SIZE-1:0] rdata_o,
  output logic                 misaligned_o
);

  logic [DATA_SIZE-1:0] shifted_s;

  assign misaligned_o = ma_misaligned(memwrite_i, ldop_i, sop_i, addr_lo_i);
  assign shifted_s    = rdata_i >> {addr_lo_i, 3'b000};

  // Store lane replication and byte strobes; loads never assert a strobe.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    if (memwrite_i) begin
      case (sop_i)
        SB: begin
          wdata_o = {4{wdata_i[7:0]}};
          wstrb_o = 4'b0001 << addr_lo_i;
        end
        SH: begin
          wdata_o = {2{wdata_i[15:0]}};
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        SW: begin
          wdata_o = wdata_i;
          wstrb_o = 4'b1111;
        end
        default: begin
          wdata_o = wdata_i;
          wstrb_o = 4'b0000;
        end
      endcase
    end else begin
      wdata_o = wdata_i;
      wstrb_o = 4'b0000;
    end
  end

  // Load extraction: the addressed byte/halfword sits at the bottom after the shift.
  always_comb begin
    rdata_o = {DATA_SIZE{1'b0}};
    case (ldop_i)
      LB:      rdata_o = {{(DATA_SIZE-8){shifted_s[7]}}, shifted_s[7:0]};
      LBU:     rdata_o = {{(DATA_SIZE-8){1'b0}}, shifted_s[7:0]};
      LH:      rdata_o = {{(DATA_SIZE-16){shifted_s[15]}}, shifted_s[15:0]};
      LHU:     rdata_o = {{(DATA_SIZE-16){1'b0}}, shifted_s[15:0]};
      LW:      rdata_o = shifted_s;
      default: rdata_o = {DATA_SIZE{1'b0}};
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: captures the execute results, issues one
// data-memory request per aligned load/store over a valid/ready bus, waits for
// the read response, and stalls upstream while the access is outstanding.
module memory_access_unit
  import multicore_pkg::*;
(
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_en,
  input  logic [DATA_SIZE-1:0] i_exe_calc,
  input  logic [DATA_SIZE-1:0] i_exe_wdata,
  input  logic                 i_cu_regwrite,
  input  logic [1:0]           i_cu_memtoreg,
  input  logic                 i_cu_memwrite,
  input  logic                 i_cu_memaccess,
  input  t_ldop                i_ldop,
  input  t_sop                 i_sop,
  input  logic [REG_AW-1:0]    i_rdest,
  input  logic [DATA_SIZE-1:0] i_pcplus4,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic [DATA_SIZE-1:0] o_ma_op,
  output logic [DATA_SIZE-1:0] o_ma_calc,
  output logic [DATA_SIZE-1:0] o_ma_rdata,
  output logic [REG_AW-1:0]    o_rdest,
  output logic                 o_cu_regwrite,
  output logic [1:0]           o_cu_memtoreg,
  output logic [DATA_SIZE-1:0] o_pcplus4,
  output logic                 o_dmem_req_valid,
  input  logic                 i_dmem_req_ready,
  output logic [DATA_SIZE-1:0] o_dmem_addr,
  output logic                 o_dmem_we,
  output logic [3:0]           o_dmem_wstrb,
  output logic [DATA_SIZE-1:0] o_dmem_wdata,
  input  logic                 i_dmem_rvalid,
  input  logic [DATA_SIZE-1:0] i_dmem_rdata
);

  t_ma_state            state_q;
  logic                 stall_q;
  logic                 req_valid_q;

  logic                 ma_regwrite_q;
  logic                 ma_memwrite_q;
  logic                 ma_memaccess_q;
  logic [1:0]           ma_memtoreg_q;

  logic [DATA_SIZE-1:0] ma_calc_q;
  logic [DATA_SIZE-1:0] ma_wdata_q;
  t_ldop                ma_ldop_q;
  t_sop                 ma_sop_q;
  logic [REG_AW-1:0]    ma_rdest_q;
  logic [DATA_SIZE-1:0] ma_pcplus4_q;
  logic [DATA_SIZE-1:0] ma_rdata_q;

  logic                 capture_s;
  logic                 in_misaligned_s;
  logic                 start_s;
  logic                 stage_mis_s;
  logic                 misaligned_s;
  logic [3:0]           wstrb_s;
  logic [DATA_SIZE-1:0] st_data_s;
  logic [DATA_SIZE-1:0] ld_ext_s;

  // The stage only advances when nothing is outstanding on the bus.
  assign capture_s       = ~stall_q;
  assign in_misaligned_s = ma_misaligned(i_cu_memwrite, i_ldop, i_sop, i_exe_calc[1:0]);
  assign start_s         = i_en & i_cu_memaccess & ~in_misaligned_s;

  mem_align_unit u_align (
    .addr_lo_i    (ma_calc_q[1:0]),
    .memwrite_i   (ma_memwrite_q),
    .ldop_i       (ma_ldop_q),
    .sop_i        (ma_sop_q),
    .wdata_i      (ma_wdata_q),
    .rdata_i      (i_dmem_rdata),
    .wstrb_o      (wstrb_s),
    .wdata_o      (st_data_s),
    .rdata_o      (ld_ext_s),
    .misaligned_o (stage_mis_s)
  );

  // Stage control bits; a bubble (i_en low) loads them as zero.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      ma_regwrite_q  <= 1'b0;
      ma_memwrite_q  <= 1'b0;
      ma_memaccess_q <= 1'b0;
      ma_memtoreg_q  <= 2'b00;
    end else if (capture_s) begin
      ma_regwrite_q  <= i_en & i_cu_regwrite;
      ma_memwrite_q  <= i_en & i_cu_memwrite;
      ma_memaccess_q <= i_en & i_cu_memaccess;
      ma_memtoreg_q  <= i_cu_memtoreg;
    end
  end

  // Stage data fields; held while the bus access is in flight.
  always_ff @(posedge i_aclk) begin
    if (capture_s) begin
      ma_calc_q    <= i_exe_calc;
      ma_wdata_q   <= i_exe_wdata;
      ma_ldop_q    <= i_ldop;
      ma_sop_q     <= i_sop;
      ma_rdest_q   <= i_rdest;
      ma_pcplus4_q <= i_pcplus4;
    end
  end

  // Latch extended read data only when a response is actually awaited.
  always_ff @(posedge i_aclk) begin
    if ((state_q == RESP) && i_dmem_rvalid) begin
      ma_rdata_q <= ld_ext_s;
    end
  end

  // Access sequencer with registered stall and request-valid.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_s) begin
            state_q     <= REQ;
            stall_q     <= 1'b1;
            req_valid_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            req_valid_q <= 1'b0;
          end
        end
        REQ: begin
          if (i_dmem_req_ready) begin
            req_valid_q <= 1'b0;
            if (ma_memwrite_q) begin
              state_q <= DONE;
              stall_q <= 1'b0;
            end else begin
              state_q <= RESP;
              stall_q <= 1'b1;
            end
          end else begin
            state_q     <= REQ;
            stall_q     <= 1'b1;
            req_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (i_dmem_rvalid) begin
            state_q <= DONE;
            stall_q <= 1'b0;
          end else begin
            state_q <= RESP;
            stall_q <= 1'b1;
          end
          req_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          stall_q     <= 1'b0;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A misaligned access never leaves IDLE, so it occupies the stage one cycle.
  assign misaligned_s     = ma_memaccess_q & stage_mis_s;

  assign o_stall          = stall_q;
  assign o_misaligned     = misaligned_s;
  assign o_ma_op          = ma_calc_q;
  assign o_ma_calc        = ma_calc_q;
  assign o_ma_rdata       = ma_rdata_q;
  assign o_rdest          = ma_rdest_q;
  assign o_cu_regwrite    = ma_regwrite_q & ~stall_q & ~misaligned_s;
  assign o_cu_memtoreg    = ma_memtoreg_q;
  assign o_pcplus4        = ma_pcplus4_q;

  assign o_dmem_req_valid = req_valid_q;
  assign o_dmem_addr      = {ma_calc_q[DATA_SIZE-1:2], 2'b00};
  assign o_dmem_we        = ma_memwrite_q;
  assign o_dmem_wstrb     = wstrb_s;
  assign o_dmem_wdata     = st_data_s;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: a table of instructions with hand-derived bus
// and write-back expectations, a scoreboard queue of write-back results, and
// hand-written reset sequences.
module tb_memory_access_unit;
  import multicore_pkg::*;

  localparam int RW = $clog2(NUM_REGS);

  logic          clk = 1'b0;
  logic          i_areset_n;
  logic          i_en;
  logic [31:0]   i_exe_calc;
  logic [31:0]   i_exe_wdata;
  logic          i_cu_regwrite;
  logic [1:0]    i_cu_memtoreg;
  logic          i_cu_memwrite;
  logic          i_cu_memaccess;
  t_ldop         i_ldop;
  t_sop          i_sop;
  logic [RW-1:0] i_rdest;
  logic [31:0]   i_pcplus4;
  logic          o_stall;
  logic          o_misaligned;
  logic [31:0]   o_ma_op;
  logic [31:0]   o_ma_calc;
  logic [31:0]   o_ma_rdata;
  logic [RW-1:0] o_rdest;
  logic          o_cu_regwrite;
  logic [1:0]    o_cu_memtoreg;
  logic [31:0]   o_pcplus4;
  logic          o_dmem_req_valid;
  logic          i_dmem_req_ready;
  logic [31:0]   o_dmem_addr;
  logic          o_dmem_we;
  logic [3:0]    o_dmem_wstrb;
  logic [31:0]   o_dmem_wdata;
  logic          i_dmem_rvalid;
  logic [31:0]   i_dmem_rdata;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .i_aclk           (clk),
    .i_areset_n       (i_areset_n),
    .i_en             (i_en),
    .i_exe_calc       (i_exe_calc),
    .i_exe_wdata      (i_exe_wdata),
    .i_cu_regwrite    (i_cu_regwrite),
    .i_cu_memtoreg    (i_cu_memtoreg),
    .i_cu_memwrite    (i_cu_memwrite),
    .i_cu_memaccess   (i_cu_memaccess),
    .i_ldop           (i_ldop),
    .i_sop            (i_sop),
    .i_rdest          (i_rdest),
    .i_pcplus4        (i_pcplus4),
    .o_stall          (o_stall),
    .o_misaligned     (o_misaligned),
    .o_ma_op          (o_ma_op),
    .o_ma_calc        (o_ma_calc),
    .o_ma_rdata       (o_ma_rdata),
    .o_rdest          (o_rdest),
    .o_cu_regwrite    (o_cu_regwrite),
    .o_cu_memtoreg    (o_cu_memtoreg),
    .o_pcplus4        (o_pcplus4),
    .o_dmem_req_valid (o_dmem_req_valid),
    .i_dmem_req_ready (i_dmem_req_ready),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_wstrb     (o_dmem_wstrb),
    .o_dmem_wdata     (o_dmem_wdata),
    .i_dmem_rvalid    (i_dmem_rvalid),
    .i_dmem_rdata     (i_dmem_rdata)
  );

  typedef struct {
    logic          en;
    logic [31:0]   calc;
    logic [31:0]   wdata;
    logic          rw;
    logic [1:0]    mtr;
    logic          mw;
    logic          ma;
    t_ldop         ldop;
    t_sop          sop;
    logic [RW-1:0] rdest;
    logic [31:0]   pc;
    int            rdy_wait;
    int            resp_wait;
    logic [31:0]   rdata;
    logic          early_rv;
    logic          e_req;
    logic [3:0]    e_wstrb;
    logic [31:0]   e_wdata;
    logic          e_mis;
    logic          e_rw;
    logic [31:0]   e_rdata;
    int            e_stall;
  } vec_t;

  typedef struct {
    logic [31:0]   calc;
    logic          rw;
    logic          mis;
    logic [RW-1:0] rdest;
    logic [1:0]    mtr;
    logic [31:0]   pc;
    logic [31:0]   rdata;
    logic          chk_rdata;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        rdata_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk_base();
    vec_t v;
    v.en = 1'b1; v.calc = 32'h0; v.wdata = 32'h0; v.rw = 1'b0; v.mtr = 2'b00;
    v.mw = 1'b0; v.ma = 1'b0; v.ldop = LW; v.sop = SW; v.rdest = '0; v.pc = 32'h0;
    v.rdy_wait = 0; v.resp_wait = 0; v.rdata = 32'h0; v.early_rv = 1'b0;
    v.e_req = 1'b0; v.e_wstrb = 4'h0; v.e_wdata = 32'h0; v.e_mis = 1'b0;
    v.e_rw = 1'b0; v.e_rdata = 32'h0; v.e_stall = 0;
    return v;
  endfunction

  function automatic vec_t mk_store(input logic [31:0] calc, input logic [31:0] wdata,
                                    input t_sop sop, input int rdy_wait, input logic e_req,
                                    input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                                    input int e_stall);
    vec_t v = mk_base();
    v.calc = calc; v.wdata = wdata; v.sop = sop; v.mw = 1'b1; v.ma = 1'b1; v.mtr = 2'b10;
    v.rdy_wait = rdy_wait; v.e_req = e_req; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
    v.e_mis = ~e_req; v.e_stall = e_stall;
    return v;
  endfunction

  function automatic vec_t mk_load(input logic [31:0] calc, input t_ldop ldop,
                                   input int rdy_wait, input int resp_wait,
                                   input logic [31:0] rdata, input logic early,
                                   input logic e_req, input logic [31:0] e_rdata,
                                   input int e_stall);
    vec_t v = mk_base();
    v.calc = calc; v.ldop = ldop; v.ma = 1'b1; v.rw = 1'b1; v.mtr = 2'b01;
    v.rdy_wait = rdy_wait; v.resp_wait = resp_wait; v.rdata = rdata; v.early_rv = early;
    v.e_req = e_req; v.e_rdata = e_rdata; v.e_mis = ~e_req; v.e_rw = e_req; v.e_stall = e_stall;
    return v;
  endfunction

  function automatic vec_t mk_alu(input logic en, input logic [31:0] calc,
                                  input logic rw, input logic ma);
    vec_t v = mk_base();
    v.en = en; v.calc = calc; v.rw = rw; v.ma = ma; v.e_rw = en & rw;
    return v;
  endfunction

  task automatic add_vec(input vec_t v);
    v.pc    = 32'h1000 + 32'(vecs.size()) * 32'd4;
    v.rdest = RW'(vecs.size() + 1);
    vecs.push_back(v);
  endtask

  task automatic set_idle_inputs();
    i_en = 1'b0; i_exe_calc = 32'h0; i_exe_wdata = 32'h0; i_cu_regwrite = 1'b0;
    i_cu_memtoreg = 2'b00; i_cu_memwrite = 1'b0; i_cu_memaccess = 1'b0;
    i_ldop = LW; i_sop = SW; i_rdest = '0; i_pcplus4 = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   stall_cnt;
    stall_cnt = 0;
    i_en = v.en; i_exe_calc = v.calc; i_exe_wdata = v.wdata; i_cu_regwrite = v.rw;
    i_cu_memtoreg = v.mtr; i_cu_memwrite = v.mw; i_cu_memaccess = v.ma;
    i_ldop = v.ldop; i_sop = v.sop; i_rdest = v.rdest; i_pcplus4 = v.pc;
    i_dmem_req_ready = 1'b0; i_dmem_rvalid = 1'b0;
    e.calc = v.calc; e.rw = v.e_rw; e.mis = v.e_mis; e.rdest = v.rdest; e.mtr = v.mtr; e.pc = v.pc;
    if (v.e_req && !v.mw) begin
      e.rdata = v.e_rdata; e.chk_rdata = 1'b1;
      last_rdata = v.e_rdata; rdata_known = 1'b1;
    end else begin
      e.rdata = last_rdata; e.chk_rdata = rdata_known;
    end
    sb.push_back(e);
    step();
    // a different instruction waits upstream; it must not enter while stalled
    i_en = 1'b1; i_exe_calc = 32'hBAD0_0000; i_cu_memaccess = 1'b0; i_cu_memwrite = 1'b0;
    i_cu_regwrite = 1'b1; i_rdest = '0; i_pcplus4 = 32'hBAD0_0004;
    if (v.e_req) begin
      if (v.early_rv) begin
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5A5A_5A5A;
      end
      for (int w = 0; w <= v.rdy_wait; w++) begin
        chk($sformatf("v%0d req_valid", idx), 32'(o_dmem_req_valid), 32'h1);
        chk($sformatf("v%0d addr", idx), o_dmem_addr, v.calc & 32'hFFFF_FFFC);
        chk($sformatf("v%0d we", idx), 32'(o_dmem_we), 32'(v.mw));
        chk($sformatf("v%0d wstrb", idx), 32'(o_dmem_wstrb), 32'(v.e_wstrb));
        if (v.mw) chk($sformatf("v%0d wdata", idx), o_dmem_wdata, v.e_wdata);
        if (w == v.rdy_wait) i_dmem_req_ready = 1'b1;
        stall_cnt += int'(o_stall);
        step();
      end
      i_dmem_req_ready = 1'b0; i_dmem_rvalid = 1'b0;
      if (!v.mw) begin
        for (int w = 0; w <= v.resp_wait; w++) begin
          chk($sformatf("v%0d resp_valid_low", idx), 32'(o_dmem_req_valid), 32'h0);
          if (w == v.resp_wait) begin
            i_dmem_rvalid = 1'b1; i_dmem_rdata = v.rdata;
          end
          stall_cnt += int'(o_stall);
          step();
        end
        i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
      end
    end
    got = sb.pop_front();
    chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'(v.e_stall));
    chk($sformatf("v%0d stall_out", idx), 32'(o_stall), 32'h0);
    chk($sformatf("v%0d no_req", idx), 32'(o_dmem_req_valid), 32'h0);
    chk($sformatf("v%0d regwrite", idx), 32'(o_cu_regwrite), 32'(got.rw));
    chk($sformatf("v%0d misaligned", idx), 32'(o_misaligned), 32'(got.mis));
    chk($sformatf("v%0d calc", idx), o_ma_calc, got.calc);
    chk($sformatf("v%0d op", idx), o_ma_op, got.calc);
    chk($sformatf("v%0d rdest", idx), 32'(o_rdest), 32'(got.rdest));
    chk($sformatf("v%0d memtoreg", idx), 32'(o_cu_memtoreg), 32'(got.mtr));
    chk($sformatf("v%0d pcplus4", idx), o_pcplus4, got.pc);
    if (got.chk_rdata) chk($sformatf("v%0d rdata", idx), o_ma_rdata, got.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // calc, wdata, sop, rdy_wait, e_req, e_wstrb, e_wdata, e_stall
    add_vec(mk_store(32'h100, 32'hDEADBEEF, SW, 0, 1'b1, 4'hF, 32'hDEADBEEF, 1));
    // calc, ldop, rdy_wait, resp_wait, rdata, early_rv, e_req, e_rdata, e_stall
    add_vec(mk_load (32'h203, LB,  0, 2, 32'h80FF_0000, 1'b0, 1'b1, 32'hFFFF_FF80, 4));
    add_vec(mk_load (32'h203, LBU, 0, 2, 32'h80FF_0000, 1'b0, 1'b1, 32'h0000_0080, 4));
    add_vec(mk_store(32'h0A2, 32'h1234ABCD, SH, 4, 1'b1, 4'hC, 32'hABCD_ABCD, 5));
    add_vec(mk_load (32'h101, LW,  0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 0));
    add_vec(mk_alu  (1'b1, 32'h0000_1234, 1'b1, 1'b0));
    add_vec(mk_load (32'h010, LW,  1, 0, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D, 3));
    add_vec(mk_load (32'h402, LH,  0, 1, 32'h8001_7FFF, 1'b0, 1'b1, 32'hFFFF_8001, 3));
    add_vec(mk_load (32'h400, LHU, 0, 0, 32'h8001_F00F, 1'b0, 1'b1, 32'h0000_F00F, 2));
    add_vec(mk_store(32'h303, 32'h0000_00A5, SB, 0, 1'b1, 4'h8, 32'hA5A5_A5A5, 1));
    add_vec(mk_store(32'h301, 32'h1234_5677, SB, 2, 1'b1, 4'h2, 32'h7777_7777, 3));
    add_vec(mk_store(32'h0A0, 32'h0000_BEEF, SH, 0, 1'b1, 4'h3, 32'hBEEF_BEEF, 1));
    add_vec(mk_store(32'h0A1, 32'h1111_2222, SH, 0, 1'b0, 4'h0, 32'h0, 0));
    add_vec(mk_store(32'h0A2, 32'h3333_4444, SW, 0, 1'b0, 4'h0, 32'h0, 0));
    add_vec(mk_alu  (1'b0, 32'h0000_0333, 1'b1, 1'b1));
    add_vec(mk_alu  (1'b1, 32'h0000_0003, 1'b1, 1'b0));
    add_vec(mk_load (32'h201, LB,  0, 0, 32'h0000_7F00, 1'b0, 1'b1, 32'h0000_007F, 2));
    add_vec(mk_load (32'h1F3, LHU, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 0));

    set_idle_inputs();
    i_dmem_req_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    i_areset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst stall", 32'(o_stall), 32'h0);
    chk("rst req_valid", 32'(o_dmem_req_valid), 32'h0);
    chk("rst misaligned", 32'(o_misaligned), 32'h0);
    chk("rst regwrite", 32'(o_cu_regwrite), 32'h0);
    chk("rst we", 32'(o_dmem_we), 32'h0);
    chk("rst wstrb", 32'(o_dmem_wstrb), 32'h0);
    i_areset_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // reset while a load waits for its response; a late rvalid must be dropped
    i_en = 1'b1; i_exe_calc = 32'h20; i_cu_memaccess = 1'b1; i_cu_memwrite = 1'b0;
    i_cu_regwrite = 1'b1; i_ldop = LW; i_rdest = RW'(3);
    step();
    set_idle_inputs();
    chk("mid req_valid", 32'(o_dmem_req_valid), 32'h1);
    i_dmem_req_ready = 1'b1;
    step();
    i_dmem_req_ready = 1'b0;
    chk("mid resp stall", 32'(o_stall), 32'h1);
    #2 i_areset_n = 1'b0;
    #1;
    chk("mid rst stall", 32'(o_stall), 32'h0);
    chk("mid rst req_valid", 32'(o_dmem_req_valid), 32'h0);
    chk("mid rst regwrite", 32'(o_cu_regwrite), 32'h0);
    chk("mid rst misaligned", 32'(o_misaligned), 32'h0);
    @(negedge clk);
    i_areset_n = 1'b1;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    step();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    chk("late rvalid rdata", o_ma_rdata, last_rdata);
    chk("late rvalid stall", 32'(o_stall), 32'h0);
    chk("late rvalid req", 32'(o_dmem_req_valid), 32'h0);

    run_vec(vecs[5], 100);
    run_vec(vecs[0], 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
